// File: rtl/clz_denormalizer.sv
// Restores a left-normalized operand by right-shifting it by its leading-zero count.
// The shift is a 5-stage logarithmic shifter, one stage per clock, with valid/ready handshakes on both sides.
module clz_denormalizer #(
    parameter bit SIGN_FILL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [AW-1:0] amt_q, amt_d;
    logic          fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          cnt_err;
    logic          cnt_full;
    logic          fill_in;

    assign cnt_err  = (|in_count[31:6]) || (in_count[5:0] > 6'd32);
    assign cnt_full = (in_count == 32'd32);
    assign fill_in  = SIGN_FILL ? in_data[31] : 1'b0;

    // Next-state, accept capture and one shifter stage per SHIFT cycle.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    fill_d  = fill_in;
                    step_d  = '0;
                    state_d = SHIFT;
                    if (cnt_err) begin
                        data_d = '0;
                        amt_d  = '0;
                        err_d  = 1'b1;
                    end else if (cnt_full) begin
                        data_d = {DW{fill_in}};
                        amt_d  = '0;
                        err_d  = 1'b0;
                    end else begin
                        data_d = in_data;
                        amt_d  = in_count[AW-1:0];
                        err_d  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                unique case (step_q)
                    3'd0: if (amt_q[4]) data_d = {{16{fill_q}}, data_q[31:16]};
                    3'd1: if (amt_q[3]) data_d = {{8{fill_q}},  data_q[31:8]};
                    3'd2: if (amt_q[2]) data_d = {{4{fill_q}},  data_q[31:4]};
                    3'd3: if (amt_q[1]) data_d = {{2{fill_q}},  data_q[31:2]};
                    default: if (amt_q[0]) data_d = {fill_q, data_q[31:1]};
                endcase
                if (step_q == 3'd4) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they carry no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            amt_q       <= '0;
            fill_q      <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            amt_q       <= amt_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_clz_denormalizer.sv
// Directed bench for clz_denormalizer; a zero-fill and a sign-fill instance share one stimulus.
module tb_clz_denormalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_count;
    logic        out_ready;
    logic        in_ready0, out_valid0, out_err0;
    logic        in_ready1, out_valid1, out_err1;
    logic [31:0] out_data0, out_data1;

    int checks;
    int failures;

    clz_denormalizer #(.SIGN_FILL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_count(in_count),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_err(out_err0)
    );

    clz_denormalizer #(.SIGN_FILL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_count(in_count),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_err(out_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) until the result is visible; garbles inputs after accept.
    task automatic do_op(input logic [31:0] d, input logic [31:0] c,
                         output logic [31:0] r0, output logic e0,
                         output logic [31:0] r1, output logic e1, output int lat);
        in_data  = d;
        in_count = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        in_count = 32'd5;
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r0 = out_data0; e0 = out_err0;
        r1 = out_data1; e1 = out_err1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; out_ready = 1'b0;
        #12;
        checks++;
        if ({in_ready0, out_valid0, out_data0, out_err0} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h err=%b, want 1 0 00000000 0",
                     in_ready0, out_valid0, out_data0, out_err0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] r0, r1; logic e0, e1; int lat;
        out_ready = 1'b0;
        do_op(32'h80000000, 32'd31, r0, e0, r1, e1, lat);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL latency_31: got %0d want 5", lat); end
        checks++;
        if (r0 !== 32'h00000001 || e0 !== 1'b0) begin
            failures++; $display("FAIL count31: got %h err=%b want 00000001 err=0", r0, e0);
        end
        checks++;
        if (in_ready0 !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b want 0", in_ready0); end
        handshake();
        checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            failures++; $display("FAIL post_hs: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
        end
        do_op(32'hB0000000, 32'd4, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h0B000000 || lat !== 5) begin
            failures++; $display("FAIL count4: got %h lat=%0d want 0B000000 lat=5", r0, lat);
        end
        checks++;
        if (r1 !== 32'hFB000000) begin failures++; $display("FAIL count4_sign: got %h want FB000000", r1); end
        handshake();
        do_op(32'hB0000000, 32'd0, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'hB0000000 || r1 !== 32'hB0000000 || lat !== 5) begin
            failures++; $display("FAIL count0: got %h/%h lat=%0d want B0000000 lat=5", r0, r1, lat);
        end
        handshake();
    endtask

    task automatic test_boundary();
        logic [31:0] r0, r1; logic e0, e1; int lat;
        do_op(32'h80000000, 32'd32, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h0 || e0 !== 1'b0 || lat !== 5) begin
            failures++; $display("FAIL count32: got %h err=%b lat=%0d want 00000000 err=0 lat=5", r0, e0, lat);
        end
        handshake();
        do_op(32'h80000000, 32'd33, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h0 || e0 !== 1'b1 || r1 !== 32'h0 || e1 !== 1'b1 || lat !== 5) begin
            failures++; $display("FAIL count33: got %h err=%b / %h err=%b want 0 err=1", r0, e0, r1, e1);
        end
        handshake();
        do_op(32'h7FFFFFFF, 32'hFFFFFFFF, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h0 || e0 !== 1'b1 || lat !== 5) begin
            failures++; $display("FAIL count_ones: got %h err=%b want 00000000 err=1", r0, e0);
        end
        handshake();
        do_op(32'h12345678, 32'd4, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h01234567 || e0 !== 1'b0) begin
            failures++; $display("FAIL err_clear: got %h err=%b want 01234567 err=0", r0, e0);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [31:0] r0, r1; logic e0, e1; int lat;
        do_op(32'h80000000, 32'd1, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h40000000) begin failures++; $display("FAIL bp_result: got %h want 40000000", r0); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hFFFF0000; in_count = 32'd8;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid0 !== 1'b1 || out_data0 !== 32'h40000000 || in_ready0 !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b data=%h rdy=%b want 1 40000000 0",
                         i, out_valid0, out_data0, in_ready0);
            end
        end
        handshake();
        checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            failures++; $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
        end
    endtask

    task automatic test_sign_fill();
        logic [31:0] r0, r1; logic e0, e1; int lat;
        do_op(32'h80000000, 32'd4, r0, e0, r1, e1, lat);
        checks++;
        if (r1 !== 32'hF8000000 || r0 !== 32'h08000000) begin
            failures++; $display("FAIL sign4: got %h/%h want F8000000/08000000", r1, r0);
        end
        handshake();
        do_op(32'h80000000, 32'd32, r0, e0, r1, e1, lat);
        checks++;
        if (r1 !== 32'hFFFFFFFF || e1 !== 1'b0) begin
            failures++; $display("FAIL sign32: got %h err=%b want FFFFFFFF err=0", r1, e1);
        end
        handshake();
    endtask

    task automatic test_mid_reset();
        logic [31:0] r0, r1; logic e0, e1; int lat;
        in_valid = 1'b1; in_data = 32'hF0000000; in_count = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready0, out_valid0, out_data0, out_err0} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got rdy=%b vld=%b data=%h err=%b want 1 0 00000000 0",
                     in_ready0, out_valid0, out_data0, out_err0);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            failures++; $display("FAIL discard: got vld=%b rdy=%b want 0 1", out_valid0, in_ready0);
        end
        do_op(32'h40000000, 32'd1, r0, e0, r1, e1, lat);
        checks++;
        if (r0 !== 32'h20000000 || r1 !== 32'h20000000 || lat !== 5) begin
            failures++; $display("FAIL after_reset: got %h/%h lat=%0d want 20000000 lat=5", r0, r1, lat);
        end
        handshake();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_sign_fill();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clz_denormalizer.md
# clz_denormalizer

Multi-cycle right-shift restorer and inverse partner of the leading-zero counter in the CPU datapath. It takes a left-normalized 32-bit operand and the 32-bit leading-zero count that produced it, then shifts the operand right by that count to rebuild the original value. The shift runs as a 5-stage logarithmic shifter, one stage per clock. Both the upstream (normalize/CLZ) side and the downstream (writeback) side use valid/ready handshakes.

## Interface
- SIGN_FILL, 0, fill bit for the right shift: 0 means zero fill, 1 means copy `in_data[31]` captured at accept.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers `in_data`/`in_count`.
- in_ready  output  1  block is idle and can accept.
- in_data  input  32  normalized operand.
- in_count  input  32  leading-zero count, same width and encoding as the CLZ output; legal range 0..32.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  restored value.
- out_err  output  1  `in_count` was greater than 32.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: carries a 3-bit step counter, 0..4.
  - DONE: `out_valid`=1.
- Accept: on a rising edge with IDLE and `in_valid`=1:
  - capture `in_data` into the data register and `in_count[4:0]` into the shift-amount register;
  - latch the fill bit;
  - clear step to 0 and go to SHIFT.
- Special counts at accept:
  - `in_count`==32: data register = 32 copies of the fill bit; shift amount = 0; `out_err`=0.
  - `in_count`>32 (any of bits [31:6] set, or value 33..63): data register = 0, shift amount = 0, error flag = 1.
  - Otherwise the error flag is cleared.
- SHIFT, step s (0..4):
  - if amount bit (4−s) is set, shift the data register right by 16, 8, 4, 2, 1 respectively, filling with the fill bit;
  - s==4 moves to DONE; otherwise step increments.
- All 5 steps always execute, including for count 0, 32 and error inputs. Latency is fixed.
- DONE: `out_data`/`out_err` are held stable while `out_valid`=1 and `out_ready`=0. On an edge with `out_ready`=1, go to IDLE.
- No pass-through: a new operand cannot be accepted in the same cycle as the result handshake.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Inputs are sampled only at the accept edge; later changes on `in_data`/`in_count` have no effect.

## Timing
- Reset values, asserted asynchronously while `rst_n`=0:
  - state=IDLE, so `in_ready`=1;
  - `out_valid`=0, `out_data`=32'h0, `out_err`=0;
  - step=0, shift amount=0, fill bit=0.
- Reset mid-SHIFT or mid-DONE aborts the operation immediately. The pending result is discarded and never presented.
- Cycle timing for an accept edge at T:
  - edges T+1..T+5 perform steps 0..4;
  - `out_valid` rises after edge T+5, so first visible in the cycle following T+5;
  - `in_ready` is 0 from after T until the cycle after the output handshake edge.
- Minimum initiation interval is 7 cycles (accept, 5 shifts, 1 DONE cycle with `out_ready`=1).
- `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from inputs.

## Test plan
- `in_data`=32'h80000000, `in_count`=31, `out_ready`=1: `out_data`=32'h00000001 and `out_err`=0, with `out_valid` first high in the cycle after edge T+5.
- `in_data`=32'hB0000000, `in_count`=4: `out_data`=32'h0B000000. Then `in_count`=0: `out_data`=`in_data` unchanged, same latency.
- Boundary counts:
  - `in_count`=32 with `in_data`=32'h80000000, SIGN_FILL=0: `out_data`=32'h0.
  - `in_count`=33 and `in_count`=32'hFFFFFFFF: `out_data`=0 and `out_err`=1. The next legal operation returns `out_err`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE. `out_valid`=1 and `out_data` stay stable, `in_ready`=0, and `in_valid` pulses are not accepted. After `out_ready`=1, `in_ready` returns the following cycle.
- SIGN_FILL=1: `in_data`=32'h80000000 with `in_count`=4 gives 32'hF8000000. With `in_count`=32 it gives 32'hFFFFFFFF.
- Assert `rst_n`=0 at step 2: all outputs go to reset values immediately. After release, `in_ready`=1, and a fresh operation (32'h40000000, count 1 -> 32'h20000000) completes correctly.
